// File: rtl/timer_arb_pkg.sv
// Shared types and helpers for the timer arbiter.
package timer_arb_pkg;

    // Largest requester count the arbiter is sized for.
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter
    import timer_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan requesters starting at ptr, wrapping, and keep the first hit.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin sharing of one down-counting timer between NUM_REQ requesters.
// Optional feature: define TIMER_ARB_CANCEL_EN to add a per-requester cancel port.
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 11
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WIDTH-1:0]     delay,
`ifdef TIMER_ARB_CANCEL_EN
    input  logic [NUM_REQ-1:0]           cancel,
`endif
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy,
    output logic [idx_width(NUM_REQ)-1:0] owner,
    output logic                         tmr_load,
    output logic                         tmr_up,
    output logic [WIDTH-1:0]             tmr_start_value,
    output logic                         tmr_enable,
    input  logic                         tmr_max_reached
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    arb_state_t         state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [WIDTH-1:0]   start_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic               busy_q;
    logic               load_q;
    logic               en_q;

    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic [WIDTH-1:0]   delay_sel;
    logic [NUM_REQ-1:0] owner_oh;
    logic [IDX_W-1:0]   ptr_next;
    logic               cancel_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (req),
        .ptr        (ptr_q),
        .winner     (win_oh),
        .winner_idx (win_idx)
    );

    // Delay slice of the current round-robin winner.
    always_comb begin
        delay_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) delay_sel = delay[i*WIDTH +: WIDTH];
        end
    end

    assign owner_oh = NUM_REQ'(1) << owner_q;
    assign ptr_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef TIMER_ARB_CANCEL_EN
    assign cancel_hit = cancel[owner_q];
`else
    assign cancel_hit = 1'b0;
`endif

    // Ownership FSM; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            start_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            load_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        owner_q <= win_idx;
                        start_q <= delay_sel;
                        gnt_q   <= win_oh;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (cancel_hit) begin
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_next;
                        state_q <= StIdle;
                    end else if (start_q == '0) begin
                        // Zero delay: nothing to time, finish immediately.
                        done_q  <= owner_oh;
                        state_q <= StDone;
                    end else begin
                        en_q    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (cancel_hit) begin
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_next;
                        state_q <= StIdle;
                    end else if (tmr_max_reached) begin
                        en_q    <= 1'b0;
                        done_q  <= owner_oh;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    ptr_q   <= ptr_next;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign gnt             = gnt_q;
    assign done            = done_q;
    assign busy            = busy_q;
    assign owner           = owner_q;
    assign tmr_load        = load_q;
    assign tmr_up          = 1'b0;
    assign tmr_start_value = start_q;
    assign tmr_enable      = en_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter with a timestamp-based reference model.
module tb_timer_arbiter;

    localparam int N = 4;
    localparam int W = 11;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] delay = '0;
    logic [N-1:0]   cancel = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [1:0]     owner;
    logic           tmr_load;
    logic           tmr_up;
    logic [W-1:0]   tmr_start_value;
    logic           tmr_enable;
    logic           tmr_max_reached;

    // Behavioural timer: loads, counts down while enabled, stops at zero.
    logic [W-1:0]   tcnt = '0;
    logic           spur = 1'b0;
    assign tmr_max_reached = (tcnt == '0) || spur;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tmr_load) tcnt <= tmr_start_value;
        else if (tmr_enable && tcnt != '0) tcnt <= tcnt - 1'b1;
    end

    timer_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .delay           (delay),
`ifdef TIMER_ARB_CANCEL_EN
        .cancel          (cancel),
`endif
        .gnt             (gnt),
        .done            (done),
        .busy            (busy),
        .owner           (owner),
        .tmr_load        (tmr_load),
        .tmr_up          (tmr_up),
        .tmr_start_value (tmr_start_value),
        .tmr_enable      (tmr_enable),
        .tmr_max_reached (tmr_max_reached)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: times of the current grant's events, in edge counts.
    int cyc = 0;
    int m_ptr = 0, m_owner = 0, m_delay = 0;
    int m_gnt = -10, m_done = -10, m_last = -10;
    int m_en_lo = 1, m_en_hi = 0, m_release = 0;

    // Observation counters.
    int gnt_cnt = 0, done_cnt = 0, g0_cnt = 0, d3_cnt = 0;
    int g_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic [N-1:0] r_s, input logic [N*W-1:0] d_s,
                                input logic rst_s, input logic [N-1:0] c_s);
        int win;
        if (!rst_s) begin
            m_ptr = 0; m_owner = 0; m_delay = 0;
            m_gnt = -10; m_done = -10; m_last = -10;
            m_en_lo = 1; m_en_hi = 0; m_release = cyc;
        end else if (c_s[m_owner] && cyc - 1 >= m_gnt && cyc - 1 < m_last) begin
            // Owner aborted during LOAD or RUN: back to idle, no done.
            m_done = -10; m_last = cyc - 1; m_en_hi = cyc - 1; m_release = cyc;
        end else if (cyc > m_release && r_s != '0) begin
            win = 0;
            for (int k = 0; k < N; k++) begin
                if (r_s[(m_ptr + k) % N]) begin
                    win = (m_ptr + k) % N;
                    break;
                end
            end
            m_owner = win;
            m_delay = int'(d_s[win*W +: W]);
            m_gnt   = cyc;
            m_done  = cyc + ((m_delay == 0) ? 1 : m_delay + 2);
            m_last  = m_done;
            if (m_delay != 0) begin
                m_en_lo = cyc + 1; m_en_hi = m_done - 1;
            end else begin
                m_en_lo = 1; m_en_hi = 0;
            end
            m_release = m_last + 1;
            m_ptr = (win + 1) % N;
        end
    endtask

    task automatic step(input int n);
        logic [N-1:0]   r_s;
        logic [N*W-1:0] d_s;
        logic           rst_s;
        logic [N-1:0]   c_s;
        logic [N-1:0]   oh;
        for (int s = 0; s < n; s++) begin
            r_s = req; d_s = delay; rst_s = reset; c_s = cancel;
            @(posedge clk);
            cyc++;
            model_update(r_s, d_s, rst_s, c_s);
            #1;
            oh = N'(1) << m_owner;
            chk("gnt", 32'(gnt), (cyc == m_gnt) ? 32'(oh) : 32'd0);
            chk("done", 32'(done), (cyc == m_done) ? 32'(oh) : 32'd0);
            chk("busy", 32'(busy), 32'(cyc >= m_gnt && cyc <= m_last));
            chk("tmr_load", 32'(tmr_load), 32'(cyc == m_gnt));
            chk("tmr_enable", 32'(tmr_enable), 32'(cyc >= m_en_lo && cyc <= m_en_hi));
            chk("owner", 32'(owner), 32'(m_owner));
            chk("start_value", 32'(tmr_start_value), 32'(m_delay));
            chk("tmr_up", 32'(tmr_up), 32'd0);
            if (gnt != '0) begin
                gnt_cnt++;
                for (int i = 0; i < N; i++) if (gnt[i]) g_log.push_back(i);
            end
            if (done != '0) done_cnt++;
            if (gnt[0]) g0_cnt++;
            if (done[3]) d3_cnt++;
        end
    endtask

    task automatic set_delay(input int i, input int d);
        delay[i*W +: W] = W'(d);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    initial begin
        int k;

        // Reset state.
        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);

        // 1: reset in the middle of a long RUN.
        req = 4'b0001; set_delay(0, 100);
        step(1);
        chk("t1_gnt", 32'(gnt), 32'b0001);
        req = '0;
        step(48);
        chk("t1_running", 32'(tmr_enable), 32'd1);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_enable", 32'(tmr_enable), 32'd0);
        done_cnt = 0;
        step(110);
        chk("t1_no_done", 32'(done_cnt), 32'd0);

        // 2: single request, delay 5.
        req = 4'b0010; set_delay(1, 5);
        step(1);
        chk("t2_gnt", 32'(gnt), 32'b0010);
        chk("t2_start", 32'(tmr_start_value), 32'd5);
        req = '0;
        for (k = 1; k <= 20; k++) begin
            step(1);
            if (done != '0) break;
        end
        chk("t2_latency", 32'(k), 32'd7);
        chk("t2_done", 32'(done), 32'b0010);
        step(3);

        // 3: all four requesting, delay 3 each: strict rotation from 0.
        do_reset();
        for (int i = 0; i < N; i++) set_delay(i, 3);
        g_log.delete();
        gnt_cnt = 0; done_cnt = 0;
        req = 4'b1111;
        for (int t = 0; t < 60 && g_log.size() < 5; t++) step(1);
        req = '0;
        step(20);
        chk("t3_ngrants", 32'(g_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < g_log.size()) chk("t3_order", 32'(g_log[i]), 32'(i % N));
        end
        chk("t3_pairing", 32'(done_cnt), 32'(gnt_cnt));

        // 4: zero delay skips RUN.
        req = 4'b0100; set_delay(2, 0);
        for (k = 1; k <= 10; k++) begin
            step(1);
            if (gnt != '0) break;
        end
        chk("t4_gnt", 32'(gnt), 32'b0100);
        req = '0;
        step(1);
        chk("t4_done", 32'(done), 32'b0100);
        chk("t4_enable", 32'(tmr_enable), 32'd0);
        step(3);

        // 5: spurious max_reached in idle; short-lived req[0] while busy.
        spur = 1'b1;
        step(3);
        chk("t5_idle", 32'(busy), 32'd0);
        spur = 1'b0;
        req = 4'b0010; set_delay(1, 10);
        step(1);
        chk("t5_gnt1", 32'(gnt), 32'b0010);
        req = '0;
        step(3);
        g0_cnt = 0;
        req = 4'b0001;
        step(2);
        req = '0;
        step(20);
        chk("t5_no_gnt0", 32'(g0_cnt), 32'd0);

`ifdef TIMER_ARB_CANCEL_EN
        // 6: owner cancels during RUN.
        do_reset();
        d3_cnt = 0;
        req = 4'b1000; set_delay(3, 50);
        step(1);
        chk("t6_gnt", 32'(gnt), 32'b1000);
        req = '0;
        step(10);
        cancel = 4'b1000;
        step(1);
        cancel = '0;
        chk("t6_busy", 32'(busy), 32'd0);
        req = 4'b1001; set_delay(0, 2); set_delay(3, 2);
        for (k = 1; k <= 10; k++) begin
            step(1);
            if (gnt != '0) break;
        end
        chk("t6_next", 32'(gnt), 32'b0001);
        req = '0;
        step(10);
        chk("t6_no_done3", 32'(d3_cnt), 32'd0);
`endif

        // Randomised traffic against the model.
        for (int t = 0; t < 400; t++) begin
            req = N'($urandom);
            for (int i = 0; i < N; i++) set_delay(i, int'($urandom_range(0, 9)));
`ifdef TIMER_ARB_CANCEL_EN
            cancel = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
`endif
            step(1);
        end
        req = '0;
        cancel = '0;
        step(15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
